// File: rtl/prbs_pkg.sv
// Shared definitions for the 16-bit PRBS generator/checker pair.
// Holds the LFSR width, the default taps, the checker state encoding and the next-bit function.
package prbs_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] DEFAULT_TAP_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        CHECK   = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic prbs_next_bit(input logic [LFSR_W-1:0] hist,
                                           input logic [LFSR_W-1:0] tap_mask);
        return ^(hist & tap_mask);
    endfunction

endpackage

// File: rtl/prbs_word_packer.sv
// Serial-to-parallel assembler: first bit lands in bit 0. word_out/word_valid register
// on the edge that takes the last bit; no backpressure, clear drops any partial word.
module prbs_word_packer
    import prbs_pkg::*;
#(
    parameter int W = LFSR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic         bit_in,
    output logic [W-1:0] word_out,
    output logic         word_valid
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    logic [CNT_W-1:0] word_bit_cnt;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_nxt;

    always_comb begin
        acc_nxt               = acc;
        acc_nxt[word_bit_cnt] = bit_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_bit_cnt <= '0;
            acc          <= '0;
            word_out     <= '0;
            word_valid   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                word_bit_cnt <= '0;
                acc          <= '0;
            end else if (en) begin
                acc <= acc_nxt;
                if (word_bit_cnt == LAST) begin
                    word_out     <= acc_nxt;
                    word_valid   <= 1'b1;
                    word_bit_cnt <= '0;
                end else begin
                    word_bit_cnt <= word_bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prbs_stream_checker.sv
// Self-synchronising PRBS checker: acquire 16 bits, verify GOOD_RUN predictions, then monitor.
// All outputs register on the edge that samples a valid bit (1 cycle); no backpressure.
module prbs_stream_checker
    import prbs_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAP_MASK = DEFAULT_TAP_MASK,
    parameter int GOOD_RUN   = 16,
    parameter int WIN        = 64,
    parameter int ERR_THRESH = 8,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              clear_err,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic              sat_flag,
    output logic [LFSR_W-1:0] word_out,
    output logic              word_valid,
    output logic [7:0]        resync_count
);

    localparam int WIN_W = $clog2(WIN + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);
    localparam logic [WIN_W-1:0] THRESH_V = WIN_W'(ERR_THRESH);
    localparam logic [7:0]       RUN_TGT  = 8'(GOOD_RUN);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t            state;
    state_t            state_nxt;
    logic [LFSR_W-1:0] hist;
    logic [3:0]        acq_cnt;
    logic [7:0]        run_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [WIN_W-1:0]  win_err;

    logic              pred;
    logic              mismatch;
    logic [LFSR_W-1:0] acq_hist;
    logic              acq_done;
    logic              err_inc;
    logic              lock_loss;
    logic [ERR_W-1:0]  err_nxt;
    logic              sat_nxt;

    always_comb begin
        pred      = prbs_next_bit(hist, TAP_MASK);
        mismatch  = bit_in ^ pred;
        acq_hist  = {hist[LFSR_W-2:0], bit_in};
        acq_done  = (acq_cnt == 4'd15);
        err_inc   = bit_valid && (state == LOCKED) && mismatch;
        lock_loss = err_inc && ((win_err + 1'b1) == THRESH_V);
    end

    always_comb begin
        state_nxt = state;
        if (bit_valid) begin
            case (state)
                ACQUIRE: if (acq_done && acq_hist != '0) state_nxt = CHECK;
                CHECK: begin
                    if (mismatch)                          state_nxt = ACQUIRE;
                    else if ((run_cnt + 8'd1) == RUN_TGT)  state_nxt = LOCKED;
                end
                LOCKED:  if (lock_loss) state_nxt = ACQUIRE;
                default: state_nxt = ACQUIRE;
            endcase
        end
    end

    // A clear on a mismatch cycle keeps that one error.
    always_comb begin
        err_nxt = err_count;
        if (clear_err)
            err_nxt = err_inc ? ERR_W'(1) : '0;
        else if (err_inc && err_count != ERR_MAX)
            err_nxt = err_count + 1'b1;
        sat_nxt = (clear_err ? 1'b0 : sat_flag) | (err_nxt == ERR_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ACQUIRE;
            hist         <= '0;
            acq_cnt      <= '0;
            run_cnt      <= '0;
            win_cnt      <= '0;
            win_err      <= '0;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= '0;
            sat_flag     <= 1'b0;
            resync_count <= '0;
        end else begin
            err_pulse <= err_inc;
            err_count <= err_nxt;
            sat_flag  <= sat_nxt;
            locked    <= (state_nxt == LOCKED);
            if (bit_valid) begin
                state <= state_nxt;
                case (state)
                    ACQUIRE: begin
                        hist    <= acq_hist;
                        acq_cnt <= acq_done ? 4'd0 : acq_cnt + 4'd1;
                        run_cnt <= '0;
                    end
                    CHECK: begin
                        // Model free-runs on its own prediction from here on.
                        hist <= {hist[LFSR_W-2:0], pred};
                        if (mismatch) begin
                            acq_cnt <= '0;
                            run_cnt <= '0;
                        end else begin
                            run_cnt <= run_cnt + 8'd1;
                        end
                    end
                    LOCKED: begin
                        hist <= {hist[LFSR_W-2:0], pred};
                        if (lock_loss) begin
                            win_cnt <= '0;
                            win_err <= '0;
                            acq_cnt <= '0;
                            run_cnt <= '0;
                            if (resync_count != 8'hFF)
                                resync_count <= resync_count + 8'd1;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            win_err <= win_err + {{(WIN_W-1){1'b0}}, mismatch};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    prbs_word_packer #(.W(LFSR_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      ((state != LOCKED) || lock_loss),
        .en         (bit_valid && (state == LOCKED)),
        .bit_in     (bit_in),
        .word_out   (word_out),
        .word_valid (word_valid)
    );

endmodule

// File: tb/tb_prbs_stream_checker.sv
// Directed bench for prbs_stream_checker: checkpoint table over a long stream plus corner sequences.
module tb_prbs_stream_checker;

    localparam int EW = 4;
    localparam int NB = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_in;
    logic          bit_valid;
    logic          clear_err;
    logic          locked;
    logic          err_pulse;
    logic [EW-1:0] err_count;
    logic          sat_flag;
    logic [15:0]   word_out;
    logic          word_valid;
    logic [7:0]    resync_count;

    always #5 clk = ~clk;

    prbs_stream_checker #(.ERR_W(EW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .clear_err    (clear_err),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .sat_flag     (sat_flag),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .resync_count (resync_count)
    );

    typedef struct {
        int            idx;
        logic          locked;
        logic          ep;
        logic [EW-1:0] ec;
        logic [7:0]    rc;
    } cp_t;

    cp_t  cps [12];
    logic model [NB];
    logic tx    [NB];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic b, input logic v, input logic clr);
        bit_in    = b;
        bit_valid = v;
        clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".locked"},  32'(locked), 0);
        chk({tag, ".ep"},      32'(err_pulse), 0);
        chk({tag, ".ec"},      32'(err_count), 0);
        chk({tag, ".sat"},     32'(sat_flag), 0);
        chk({tag, ".word"},    32'(word_out), 0);
        chk({tag, ".wv"},      32'(word_valid), 0);
        chk({tag, ".resync"},  32'(resync_count), 0);
    endtask

    function automatic logic is_inv(input int i);
        return (i == 100) || (i >= 170 && i <= 184 && (i % 2) == 0);
    endfunction

    function automatic logic [15:0] tx_word(input int last);
        logic [15:0] w;
        for (int k = 0; k < 16; k++) w[k] = tx[last - 15 + k];
        return w;
    endfunction

    initial begin
        logic [15:0] g;
        logic        exp_wv;
        int          gap;

        g = 16'hACE1;
        for (int i = 0; i < NB; i++) begin
            model[i] = ^(g & 16'hB400);
            g        = {g[14:0], model[i]};
        end

        cps[0]  = '{15,  1'b0, 1'b0, 4'd0, 8'd0};
        cps[1]  = '{30,  1'b0, 1'b0, 4'd0, 8'd0};
        cps[2]  = '{31,  1'b1, 1'b0, 4'd0, 8'd0};
        cps[3]  = '{99,  1'b1, 1'b0, 4'd0, 8'd0};
        cps[4]  = '{100, 1'b1, 1'b1, 4'd1, 8'd0};
        cps[5]  = '{101, 1'b1, 1'b0, 4'd1, 8'd0};
        cps[6]  = '{182, 1'b1, 1'b1, 4'd8, 8'd0};
        cps[7]  = '{183, 1'b1, 1'b0, 4'd8, 8'd0};
        cps[8]  = '{184, 1'b0, 1'b1, 4'd9, 8'd1};
        cps[9]  = '{215, 1'b0, 1'b0, 4'd9, 8'd1};
        cps[10] = '{216, 1'b1, 1'b0, 4'd9, 8'd1};
        cps[11] = '{259, 1'b1, 1'b0, 4'd9, 8'd1};

        // Reset state
        do_reset();
        chk_zero("reset");

        // Lock, single error, burst loss of lock and reacquisition
        for (int i = 0; i < 260; i++) begin
            tx[i] = model[i] ^ is_inv(i);
            send(tx[i], 1'b1, 1'b0);
            exp_wv = (i >= 47 && i <= 175 && ((i - 47) % 16) == 0) ||
                     (i >= 232 && ((i - 232) % 16) == 0);
            chk($sformatf("main.wv[%0d]", i), 32'(word_valid), 32'(exp_wv));
            chk($sformatf("main.ep[%0d]", i), 32'(err_pulse), 32'(is_inv(i)));
            if (exp_wv && word_valid)
                chk($sformatf("main.word[%0d]", i), 32'(word_out), 32'(tx_word(i)));
            foreach (cps[k]) begin
                if (cps[k].idx == i) begin
                    chk($sformatf("cp.locked[%0d]", i), 32'(locked), 32'(cps[k].locked));
                    chk($sformatf("cp.ep[%0d]", i),     32'(err_pulse), 32'(cps[k].ep));
                    chk($sformatf("cp.ec[%0d]", i),     32'(err_count), 32'(cps[k].ec));
                    chk($sformatf("cp.rc[%0d]", i),     32'(resync_count), 32'(cps[k].rc));
                end
            end
        end

        // All-zero input never leaves acquisition; a real stream afterwards locks after 32 bits
        do_reset();
        for (int i = 0; i < 48; i++) begin
            send(1'b0, 1'b1, 1'b0);
            if (locked || err_pulse || word_valid)
                chk($sformatf("zero.outs[%0d]", i), {29'd0, locked, err_pulse, word_valid}, 0);
        end
        chk("zero.locked", 32'(locked), 0);
        chk("zero.ec", 32'(err_count), 0);
        for (int i = 0; i < 32; i++) begin
            send(model[i], 1'b1, 1'b0);
            if (i == 30) chk("zero.lock30", 32'(locked), 0);
        end
        chk("zero.lock31", 32'(locked), 1);

        // Idle gaps: same lock latency counted in valid bits, nothing pulses on idle cycles
        do_reset();
        for (int i = 0; i < 50; i++) begin
            send(model[i], 1'b1, 1'b0);
            chk($sformatf("idle.locked[%0d]", i), 32'(locked), 32'(i >= 31));
            chk($sformatf("idle.wv[%0d]", i), 32'(word_valid), 32'(i == 47));
            if (i == 47) begin
                for (int k = 0; k < 16; k++) tx[32 + k] = model[32 + k];
                chk("idle.word", 32'(word_out), 32'(tx_word(47)));
            end
            gap = (i == 20) ? 3 : 1;
            for (int j = 0; j < gap; j++) begin
                send(~model[i + 1], 1'b0, 1'b0);
                if (err_pulse || word_valid || (locked != (i >= 31)))
                    chk($sformatf("idle.gap[%0d]", i), {30'd0, err_pulse, word_valid}, 0);
            end
        end

        // Error counter saturation and clear on a mismatch cycle
        do_reset();
        for (int i = 0; i < 254; i++) begin
            logic inv;
            inv = (i >= 50 && i <= 250 && ((i - 50) % 10) == 0) || (i == 253);
            send(model[i] ^ inv, 1'b1, (i == 250) || (i == 251));
            if (i == 180) begin
                chk("sat.ec14", 32'(err_count), 14);
                chk("sat.flag14", 32'(sat_flag), 0);
            end
            if (i == 190) begin
                chk("sat.ec15", 32'(err_count), 15);
                chk("sat.flag15", 32'(sat_flag), 1);
            end
            if (i == 249) begin
                chk("sat.hold", 32'(err_count), 15);
                chk("sat.flag", 32'(sat_flag), 1);
                chk("sat.locked", 32'(locked), 1);
            end
            if (i == 250) begin
                chk("clr.ec", 32'(err_count), 1);
                chk("clr.flag", 32'(sat_flag), 0);
                chk("clr.ep", 32'(err_pulse), 1);
                chk("clr.locked", 32'(locked), 1);
                chk("clr.resync", 32'(resync_count), 0);
            end
            if (i == 251) chk("clr.ec0", 32'(err_count), 0);
        end
        chk("pre_rst.ep", 32'(err_pulse), 1);
        chk("pre_rst.ec", 32'(err_count), 1);

        // Asynchronous reset mid-LOCKED, checked before the next clock edge
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
